// File: rtl/regfile_arbiter.sv
// Round-robin arbiter/sequencer granting N_REQ requesters one access at a time to a shared 8x8 register file.
// Optional write protection is enabled by defining REGFILE_ARB_WPROT_EN (adds wprot_mask input, drives err).
module regfile_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int N_REQ      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
`ifdef REGFILE_ARB_WPROT_EN
    input  logic [2**ADDR_WIDTH-1:0]      wprot_mask,
`endif
    output logic [N_REQ-1:0]              gnt,
    output logic [N_REQ-1:0]              done,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          err,
    output logic                          rf_enable,
    output logic                          rf_write_en,
    output logic [ADDR_WIDTH-1:0]         rf_write_addr,
    output logic [DATA_WIDTH-1:0]         rf_write_data,
    output logic [ADDR_WIDTH-1:0]         rf_read_addr,
    input  logic [DATA_WIDTH-1:0]         rf_read_data
);

    localparam int              OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [OW:0]     NREQ_W   = (OW+1)'(N_REQ);
    localparam logic [OW-1:0]   LAST_RST = OW'(N_REQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic [OW-1:0]         last_owner_q, last_owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  wr_block_s;

    logic                  found_s;
    logic [OW-1:0]         winner_s;
    logic [OW:0]           sum_s;
    logic [OW:0]           cand_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;

`ifdef REGFILE_ARB_WPROT_EN
    logic prot_q, prot_d;
    assign wr_block_s = prot_q;
`else
    assign wr_block_s = 1'b0;
`endif

    // Round-robin search starting just after the last owner, wrapping modulo N_REQ.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {OW{1'b0}};
        sum_s    = {(OW+1){1'b0}};
        cand_s   = {(OW+1){1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            sum_s  = {1'b0, last_owner_q} + (OW+1)'(k);
            cand_s = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
            if (!found_s && req[cand_s[OW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = cand_s[OW-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Select the winning requester's operation fields.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        sel_wdata_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (winner_s == OW'(i)) begin
                sel_we_s    = req_we[i];
                sel_addr_s  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_s = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_we_s    = sel_we_s;
            end
        end
    end

    // IDLE -> ISSUE -> DONE sequencing and operation latching.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef REGFILE_ARB_WPROT_EN
        prot_d       = prot_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d      = S_ISSUE;
                    owner_d      = winner_s;
                    last_owner_d = winner_s;
                    we_d         = sel_we_s;
                    addr_d       = sel_addr_s;
                    wdata_d      = sel_wdata_s;
`ifdef REGFILE_ARB_WPROT_EN
                    prot_d       = wprot_mask[sel_addr_s];
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_DONE;
                err_d   = we_q & wr_block_s;
                if (!we_q) begin
                    rdata_d = rf_read_data;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= {OW{1'b0}};
            last_owner_q <= LAST_RST;
            we_q         <= 1'b0;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            wdata_q      <= {DATA_WIDTH{1'b0}};
            rdata_q      <= {DATA_WIDTH{1'b0}};
            err_q        <= 1'b0;
`ifdef REGFILE_ARB_WPROT_EN
            prot_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef REGFILE_ARB_WPROT_EN
            prot_q       <= prot_d;
`endif
        end
    end

    // One-hot grant/done decoded from the registered owner and state.
    always_comb begin
        gnt  = {N_REQ{1'b0}};
        done = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i]  = (state_q == S_ISSUE) && (owner_q == OW'(i));
            done[i] = (state_q == S_DONE)  && (owner_q == OW'(i));
        end
    end

    // rst gates the write strobe so nothing lands while the register file is clearing.
    assign rf_enable     = (state_q == S_ISSUE);
    assign rf_write_en   = (state_q == S_ISSUE) & we_q & ~wr_block_s & ~rst;
    assign rf_write_addr = addr_q;
    assign rf_write_data = wdata_q;
    assign rf_read_addr  = addr_q;
    assign rdata         = rdata_q;
    assign err           = err_q;

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 8x8 register file (single write port, single combinational read port) among N_REQ requesters.
- Grants one requester at a time, drives the register file's enable, write and read ports, and returns read data with a done pulse.
- Sits between client blocks (e.g. a test sequencer and a datapath) and the register file.
- The register file shares clk/rst with this block.

Parameters:
- DATA_WIDTH, 8, register width.
- ADDR_WIDTH, 3, register address width (8 registers).
- N_REQ, 2, number of requesters (legal range 2..4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request per requester; held high until the matching gnt is seen.
- req_we  input  N_REQ  1 = write, 0 = read; per requester.
- req_addr  input  N_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  N_REQ*DATA_WIDTH  flattened write data; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  N_REQ  one-hot; high for the single ISSUE cycle of the granted requester.
- done  output  N_REQ  one-hot; one-cycle pulse in DONE for the owner.
- rdata  output  DATA_WIDTH  registered read result; valid while done is high, held until the next read.
- err  output  1  high with done when a write was suppressed (see Optional Feature).
- rf_enable  output  1  to register file enable.
- rf_write_en  output  1  to register file write_en.
- rf_write_addr  output  ADDR_WIDTH  to register file write_addr.
- rf_write_data  output  DATA_WIDTH  to register file write_data.
- rf_read_addr  output  ADDR_WIDTH  to register file read_addr.
- rf_read_data  input  DATA_WIDTH  from register file read_data (combinational).

Behaviour:
- FSM states:
  - IDLE: if any req bit is high, pick a winner, latch owner/we/addr/wdata, go to ISSUE; otherwise stay.
  - ISSUE: drive the register file for one cycle, go to DONE.
  - DONE: pulse done, go to IDLE.
  - Throughput: one access per 3 cycles.
- Arbitration:
  - Search starts at (last_owner+1) mod N_REQ and ascends with wrap; first requester with req high wins.
  - last_owner updates on each grant; reset value N_REQ-1, so requester 0 wins first after reset.
- req is sampled only in IDLE. req in ISSUE/DONE is ignored. A requester that drops req before grant is not served.
- ISSUE drives:
  - rf_enable=1, rf_read_addr=latched addr.
  - rf_write_addr=latched addr, rf_write_data=latched wdata.
  - rf_write_en=latched we AND NOT rst.
  - gnt[owner]=1.
- Outside ISSUE: rf_enable=0, rf_write_en=0; address/data outputs hold their last latched values.
- At the ISSUE→DONE edge:
  - Write: the register file commits the write.
  - Read: rdata <= rf_read_data.
  - Write leaves rdata unchanged.
- Latency: req high at edge k (IDLE) → gnt high cycle k+1 → done high cycle k+2 → IDLE at k+3.
- Read-after-write from any requester returns the new value; ops never overlap.
- Reset (synchronous, any state) at the next edge:
  - state=IDLE, gnt=0, done=0, err=0, rdata=0, last_owner=N_REQ-1.
  - Latched fields=0, rf_* outputs=0.
- Reset during ISSUE: rf_write_en is forced 0 in that cycle, so no write lands while the register file is clearing.
- Simultaneous requests: exactly one grant per ISSUE; the losers stay pending and are served in rotation.
- Address width: no range check; all 2**ADDR_WIDTH addresses are legal.

Optional Feature:
- Macro: REGFILE_ARB_WPROT_EN.
- Defined:
  - Adds input wprot_mask [2**ADDR_WIDTH-1:0].
  - Mask is sampled in IDLE with the request.
  - A write to an address whose mask bit is 1 is suppressed: rf_write_en stays 0 in ISSUE, done still pulses, err=1 in the same DONE cycle.
  - Reads are never suppressed.
- Not defined: no wprot_mask port, err tied to 0, all writes proceed.

Test Plan:
1. Reset, then req0 write addr 3 data AA → gnt[0] one cycle after req; register 3 = AA; done[0] at cycle +2. Then req0 read addr 3 → rdata=AA with done[0].
2. req0 and req1 both high from reset; req0 write addr 5=55, req1 write addr 6=66 → gnt[0] first, then gnt[1] 3 cycles later. Both then reissue reads → first read granted to req0 (last_owner=1), rdata 55 then 66.
3. Both requesters hold req continuously for 6 ops → gnt alternates 0,1,0,1,0,1; no starvation; each gnt exactly one cycle; never two gnt bits high.
4. req1 writes addr 2=C3, then req0 reads addr 2 immediately → rdata=C3; rf_enable high only in ISSUE cycles.
5. rst asserted during the ISSUE of a write of addr 4=5A → no write; register 4 reads 00; FSM in IDLE next cycle; gnt/done/rdata=0.
6. With REGFILE_ARB_WPROT_EN and wprot_mask=8'h01:
   - write addr 0=FF → done with err=1; read addr 0 → 00.
   - write addr 1=FF → err=0; read → FF.
